tree_walk_ctrl: RTL

//  Sequences one decision-tree inference over a synchronous tree node ROM (1-cycle read latency).

---
 rtl/tree_pkg.sv | 54 +++++
 rtl/tree_fp64_cmp.sv | 13 +
 rtl/tree_walk_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tree_pkg.sv
// Shared types and field layout for the decision-tree walker.
// Node word layout (low-aligned, 108 bits used):
//   [107:96] node_id  [95:92] feat_idx  [91:28] threshold (fp64)
//   [27:16]  left     [15:4]  right     [3:0]   tag
package tree_pkg;

  localparam int NODE_ID_LSB   = 96;
  localparam int NODE_ID_W     = 12;
  localparam int FEAT_LSB      = 92;
  localparam int FEAT_W        = 4;
  localparam int THR_LSB       = 28;
  localparam int THR_W         = 64;
  localparam int LEFT_LSB      = 16;
  localparam int RIGHT_LSB     = 4;
  localparam int CHILD_W       = 12;
  localparam int TAG_LSB       = 0;
  localparam int TAG_W         = 4;
  localparam int NODE_FIELDS_W = 108;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_DEPTH = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_ID    = 2'd3;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  typedef struct {
    logic [NODE_ID_W-1:0] node_id;
    logic [FEAT_W-1:0]    feat_idx;
    logic [THR_W-1:0]     threshold;
    logic [CHILD_W-1:0]   left;
    logic [CHILD_W-1:0]   right;
    logic [TAG_W-1:0]     tag;
  } node_t;

  // Split a raw ROM word into its named fields.
  function automatic node_t unpack_node(input logic [NODE_FIELDS_W-1:0] w);
    node_t n;
    n.node_id   = w[NODE_ID_LSB +: NODE_ID_W];
    n.feat_idx  = w[FEAT_LSB +: FEAT_W];
    n.threshold = w[THR_LSB +: THR_W];
    n.left      = w[LEFT_LSB +: CHILD_W];
    n.right     = w[RIGHT_LSB +: CHILD_W];
    n.tag       = w[TAG_LSB +: TAG_W];
    return n;
  endfunction

  // Map an fp64 bit pattern onto an unsigned key with the same ordering
  // (negatives reversed below positives, -0.0 just below +0.0).
  function automatic logic [63:0] fp64_key(input logic [63:0] x);
    return x[63] ? ~x : (x ^ 64'h8000_0000_0000_0000);
  endfunction

endpackage

// File: rtl/tree_fp64_cmp.sv
// Combinational total-order fp64 compare: le = (a <= b).
// No NaN special-casing; the ordering is purely on the mapped bit key.
module tree_fp64_cmp
  import tree_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        le
);

  assign le = (fp64_key(a) <= fp64_key(b));

endmodule

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walk sequencer over a 1-cycle-latency node ROM.
// Each visited node costs a FETCH cycle (ROM samples rom_addr) and an
// EVAL cycle (node_data valid, feature compared, next step chosen).
// Optional build macro: TREE_WALK_STATS_EN -- when defined, result_nodes
// reports the number of nodes visited; otherwise it is tied to zero.
module tree_walk_ctrl
  import tree_pkg::*;
#(
  parameter int NODE_WIDTH = 120,
  parameter int ADDR_WIDTH = 10,
  parameter int TREE_NODES = 245,
  parameter int ROOT_ADDR  = 0,
  parameter int MAX_DEPTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_valid,
  output logic                               start_ready,
  output logic [ADDR_WIDTH-1:0]              rom_addr,
  input  logic [NODE_WIDTH-1:0]              node_data,
  output logic [3:0]                         feat_idx,
  input  logic [63:0]                        feat_val,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [3:0]                         result_class,
  output logic [1:0]                         result_err,
  output logic [$clog2(MAX_DEPTH+1)-1:0]     result_nodes
);

  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] ROOT       = ADDR_WIDTH'(ROOT_ADDR);
  localparam logic [CW-1:0]         DEPTH_LAST = CW'(MAX_DEPTH);
  localparam logic [31:0]           NODE_LIMIT = TREE_NODES;

  state_t          state;
  logic [CW-1:0]   depth;
  logic [CW-1:0]   depth_next;
  node_t           node;
  logic            go_left;
  logic [CHILD_W-1:0] child;
  logic            is_leaf;
  logic            id_bad;
  logic            child_oob;
  logic            eval_done;
  logic [1:0]      eval_err;
  logic [3:0]      eval_class;
  logic            unused_bits;

  // ROM bits above the node fields carry nothing for the walk.
  assign unused_bits = ^node_data[NODE_WIDTH-1:NODE_FIELDS_W];

  // Decode the current ROM word into named fields.
  always_comb begin
    node = unpack_node(node_data[NODE_FIELDS_W-1:0]);
  end

  // Feature select goes straight out so feat_val returns within EVAL.
  assign feat_idx = node.feat_idx;

  tree_fp64_cmp u_cmp (
    .a  (feat_val),
    .b  (node.threshold),
    .le (go_left)
  );

  assign depth_next = depth + 1'b1;
  assign child      = go_left ? node.left : node.right;
  assign is_leaf    = (node.left == '0) && (node.right == '0);
  assign id_bad     = (node.node_id != NODE_ID_W'(rom_addr));
  assign child_oob  = ({{(32-CHILD_W){1'b0}}, child} >= NODE_LIMIT);

  // Resolve the EVAL outcome in priority order: id, leaf, depth, range.
  always_comb begin
    eval_done  = 1'b1;
    eval_err   = ERR_OK;
    eval_class = 4'd0;
    if (id_bad) begin
      eval_err = ERR_ID;
    end else if (is_leaf) begin
      eval_class = node.tag;
    end else if (depth_next == DEPTH_LAST) begin
      eval_err = ERR_DEPTH;
    end else if (child_oob) begin
      eval_err = ERR_RANGE;
    end else begin
      eval_done = 1'b0;
    end
  end

`ifdef TREE_WALK_STATS_EN
  logic [CW-1:0] nodes_q;
  assign result_nodes = nodes_q;
`else
  assign result_nodes = '0;
`endif

  // Walk FSM with registered handshake, address and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rom_addr     <= ROOT;
      depth        <= '0;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      result_class <= 4'd0;
      result_err   <= ERR_OK;
`ifdef TREE_WALK_STATS_EN
      nodes_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            rom_addr    <= ROOT;
            depth       <= '0;
            start_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          state <= EVAL;
        end
        EVAL: begin
          depth <= depth_next;
          if (eval_done) begin
            result_valid <= 1'b1;
            result_class <= eval_class;
            result_err   <= eval_err;
`ifdef TREE_WALK_STATS_EN
            nodes_q      <= depth_next;
`endif
            state        <= DONE;
          end else begin
            rom_addr <= ADDR_WIDTH'(child);
            state    <= FETCH;
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
